// File: rtl/dmem_arb_pkg.sv
// Shared types and width helpers for the data-memory arbiter (dmem_arbiter).
package dmem_arb_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    // Requester-index width; a single requester still needs one bit.
    function automatic int ptr_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // Lock counter must be able to hold MAX_LOCK itself.
    function automatic int lcnt_w(input int max_lock);
        return $clog2(max_lock + 1);
    endfunction

endpackage

// File: rtl/dmem_arb_picker.sv
// Combinational winner picker: fixed priority by default, round-robin from a
// start pointer when DMEM_ARB_RR_EN is defined.
module dmem_arb_picker #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
`ifdef DMEM_ARB_RR_EN
    input  logic [PTR_W-1:0]   start,
`endif
    output logic [NUM_REQ-1:0] win_oh,
    output logic [PTR_W-1:0]   win_idx,
    output logic               win_any
);

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path leaves a latch.
        win_oh  = '0;
        win_idx = '0;
        win_any = 1'b0;
`ifdef DMEM_ARB_RR_EN
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_any && req[(int'(start) + k) % NUM_REQ]) begin
                win_any                                = 1'b1;
                win_idx                                = PTR_W'((int'(start) + k) % NUM_REQ);
                win_oh[(int'(start) + k) % NUM_REQ]    = 1'b1;
            end
        end
`else
        // Scan downwards so the lowest valid index is the last to overwrite.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_oh    = '0;
                win_oh[i] = 1'b1;
                win_idx   = PTR_W'(i);
                win_any   = 1'b1;
            end
        end
`endif
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter with locked bursts and 1-cycle read response routing.
// Define DMEM_ARB_RR_EN for round-robin picking; otherwise fixed priority (index 0 highest).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_gnt,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [ADDR_W-1:0]         mem_address,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic                      mem_read,
    output logic                      mem_write,
    input  logic [DATA_W-1:0]         mem_rdata
);

    localparam int PTR_W  = ptr_w(NUM_REQ);
    localparam int LCNT_W = lcnt_w(MAX_LOCK);

    arb_state_t          state, state_nxt;
    logic [PTR_W-1:0]    owner, owner_nxt;
    logic [LCNT_W-1:0]   lock_cnt, lock_cnt_nxt;
    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  pick_oh;
    logic [PTR_W-1:0]    pick_idx;
    logic                pick_any;
    logic                grant;
    logic                win_we;
    logic                forced_release;

    // While locked, only the owner may compete.
    always_comb begin
        eligible = req_valid;
        if (state == ST_LOCKED) begin
            eligible        = '0;
            eligible[owner] = req_valid[owner];
        end
    end

`ifdef DMEM_ARB_RR_EN
    logic [PTR_W-1:0] rr_ptr, rr_ptr_nxt;

    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction
`endif

    dmem_arb_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req     (eligible),
`ifdef DMEM_ARB_RR_EN
        .start   (rr_ptr),
`endif
        .win_oh  (pick_oh),
        .win_idx (pick_idx),
        .win_any (pick_any)
    );

    // Reset gates every memory-side strobe so nothing escapes while rst_n is low.
    assign grant          = pick_any & rst_n;
    assign win_we         = req_we[pick_idx];
    assign req_gnt        = grant ? pick_oh : '0;
    assign mem_read       = grant & ~win_we;
    assign mem_write      = grant &  win_we;
    assign mem_address    = grant ? req_addr[int'(pick_idx)*ADDR_W +: ADDR_W]  : '0;
    assign mem_wdata      = grant ? req_wdata[int'(pick_idx)*DATA_W +: DATA_W] : '0;
    assign rsp_rdata      = mem_rdata;
    assign forced_release = (state == ST_LOCKED) && (lock_cnt == LCNT_W'(MAX_LOCK));

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        lock_cnt_nxt = lock_cnt;
        case (state)
            ST_IDLE: begin
                if (grant && req_lock[pick_idx]) begin
                    state_nxt    = ST_LOCKED;
                    owner_nxt    = pick_idx;
                    lock_cnt_nxt = LCNT_W'(1);
                end
            end
            ST_LOCKED: begin
                lock_cnt_nxt = lock_cnt + 1'b1;
                if (!req_lock[owner] || forced_release) begin
                    state_nxt    = ST_IDLE;
                    lock_cnt_nxt = '0;
                end
            end
        endcase
    end

`ifdef DMEM_ARB_RR_EN
    always_comb begin
        rr_ptr_nxt = rr_ptr;
        if (grant)
            rr_ptr_nxt = next_idx(pick_idx);
        else if (forced_release)
            rr_ptr_nxt = next_idx(owner);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            rr_ptr <= '0;
        else
            rr_ptr <= rr_ptr_nxt;
    end
`endif

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
        if (!rst_n) begin
            state     <= ST_IDLE;
            owner     <= '0;
            lock_cnt  <= '0;
            rsp_valid <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            lock_cnt  <= lock_cnt_nxt;
            rsp_valid <= req_gnt & ~req_we;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table plus lock, forced-release
// and reset sequences, with a small registered memory model on the memory port.
module tb_dmem_arbiter;

    localparam int NUM_REQ  = 2;
    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 32;
    localparam int MAX_LOCK = 16;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid, req_we, req_lock;
    logic [19:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_gnt, rsp_valid;
    logic [31:0] rsp_rdata, mem_wdata, mem_rdata;
    logic [9:0]  mem_address;
    logic        mem_read, mem_write;
    logic [31:0] mem [0:1023];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_LOCK (MAX_LOCK)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_lock    (req_lock),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_gnt     (req_gnt),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_rdata   (mem_rdata)
    );

    // Single-port memory with registered read data.
    always @(posedge clk) begin
        if (mem_write) mem[mem_address] <= mem_wdata;
        if (mem_read)  mem_rdata <= mem[mem_address];
    end

    typedef struct {
        logic [1:0]  v, we, lk;
        logic [9:0]  a0, a1;
        logic [31:0] d0, d1;
        logic [1:0]  gnt;
        logic        rd, wr;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [1:0]  rsp;     // response visible during this row's cycle
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                         input logic [9:0] a0, input logic [9:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
        req_valid = v;
        req_we    = we;
        req_lock  = lk;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(2'b00, 2'b00, 2'b00, 10'd0, 10'd0, 32'd0, 32'd0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    function automatic logic [1:0] contend_exp(input int c);
`ifdef DMEM_ARB_RR_EN
        return (c % 2 == 0) ? 2'b01 : 2'b10;
`else
        return (c >= 0) ? 2'b01 : 2'b10;
`endif
    endfunction

    logic [1:0] prev_g;
    logic [1:0] exp_g;
    logic [1:0] lk_v  [6];
    logic       lk_l1 [6];
    logic [1:0] lk_e  [6];

    initial begin
        //          v      we     lk     a0       a1      d0            d1            gnt    rd    wr    addr     wdata         rsp    rdata
        vecs[0] = '{2'b00, 2'b00, 2'b00, 10'd0,   10'd0,  32'h0,        32'h0,        2'b00, 1'b0, 1'b0, 10'd0,   32'h0,        2'b00, 32'h0};
        vecs[1] = '{2'b01, 2'b01, 2'b00, 10'd5,   10'd0,  32'hDEADBEEF, 32'h0,        2'b01, 1'b0, 1'b1, 10'd5,   32'hDEADBEEF, 2'b00, 32'h0};
        vecs[2] = '{2'b01, 2'b00, 2'b00, 10'd5,   10'd0,  32'h0,        32'h0,        2'b01, 1'b1, 1'b0, 10'd5,   32'h0,        2'b00, 32'h0};
        vecs[3] = '{2'b10, 2'b10, 2'b00, 10'd0,   10'd10, 32'h0,        32'h12345678, 2'b10, 1'b0, 1'b1, 10'd10,  32'h12345678, 2'b01, 32'hDEADBEEF};
        vecs[4] = '{2'b10, 2'b00, 2'b00, 10'd0,   10'd10, 32'h0,        32'h0,        2'b10, 1'b1, 1'b0, 10'd10,  32'h0,        2'b00, 32'h0};
        vecs[5] = '{2'b00, 2'b00, 2'b01, 10'd7,   10'd0,  32'h0,        32'h0,        2'b00, 1'b0, 1'b0, 10'd0,   32'h0,        2'b10, 32'h12345678};
        vecs[6] = '{2'b10, 2'b00, 2'b00, 10'd0,   10'd5,  32'h0,        32'h0,        2'b10, 1'b1, 1'b0, 10'd5,   32'h0,        2'b00, 32'h0};
        vecs[7] = '{2'b01, 2'b01, 2'b00, 10'd1023,10'd0,  32'hFFFFFFFF, 32'h0,        2'b01, 1'b0, 1'b1, 10'd1023,32'hFFFFFFFF, 2'b10, 32'hDEADBEEF};
        vecs[8] = '{2'b01, 2'b00, 2'b00, 10'd1023,10'd0,  32'h0,        32'h0,        2'b01, 1'b1, 1'b0, 10'd1023,32'h0,        2'b00, 32'h0};
        vecs[9] = '{2'b00, 2'b00, 2'b00, 10'd0,   10'd0,  32'h0,        32'h0,        2'b00, 1'b0, 1'b0, 10'd0,   32'h0,        2'b01, 32'hFFFFFFFF};

        // Reset held with both requesters active: everything gated off.
        drive(2'b11, 2'b01, 2'b11, 10'd3, 10'd4, 32'h1, 32'h2);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check($sformatf("rst%0d gnt", c), req_gnt, 2'b00);
            check($sformatf("rst%0d mem_read", c), mem_read, 1'b0);
            check($sformatf("rst%0d mem_write", c), mem_write, 1'b0);
            check($sformatf("rst%0d rsp_valid", c), rsp_valid, 2'b00);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].v, vecs[i].we, vecs[i].lk, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
            @(negedge clk);
            check($sformatf("vec%0d gnt", i), req_gnt, vecs[i].gnt);
            check($sformatf("vec%0d mem_read", i), mem_read, vecs[i].rd);
            check($sformatf("vec%0d mem_write", i), mem_write, vecs[i].wr);
            check($sformatf("vec%0d mem_address", i), mem_address, vecs[i].addr);
            check($sformatf("vec%0d mem_wdata", i), mem_wdata, vecs[i].wdata);
            check($sformatf("vec%0d rsp_valid", i), rsp_valid, vecs[i].rsp);
            if (vecs[i].rsp != 2'b00)
                check($sformatf("vec%0d rsp_rdata", i), rsp_rdata, vecs[i].rdata);
            next_cycle();
        end

        // Contention: both read continuously from a fresh reset.
        do_reset();
        drive(2'b11, 2'b00, 2'b00, 10'd5, 10'd10, 32'h0, 32'h0);
        prev_g = 2'b00;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            exp_g = contend_exp(c);
            check($sformatf("contend%0d gnt", c), req_gnt, exp_g);
            check($sformatf("contend%0d rsp_valid", c), rsp_valid, prev_g);
            if (prev_g != 2'b00)
                check($sformatf("contend%0d rsp_rdata", c), rsp_rdata,
                      (prev_g == 2'b01) ? 32'hDEADBEEF : 32'h12345678);
            prev_g = exp_g;
            next_cycle();
        end
        drive(2'b00, 2'b00, 2'b00, 10'd0, 10'd0, 32'h0, 32'h0);
        @(negedge clk);
        check("contend_tail rsp_valid", rsp_valid, prev_g);

        // Lock by req1 while req0 waits, including an owner idle beat.
        next_cycle();
        do_reset();
        lk_v  = '{2'b10, 2'b11, 2'b01, 2'b11, 2'b11, 2'b11};
        lk_l1 = '{1'b1,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0};
        lk_e  = '{2'b10, 2'b10, 2'b00, 2'b10, 2'b10, 2'b01};
        for (int c = 0; c < 6; c++) begin
            drive(lk_v[c], 2'b11, {lk_l1[c], 1'b0}, 10'd20, 10'd21, 32'hA0, 32'hB1);
            @(negedge clk);
            check($sformatf("lock%0d gnt", c), req_gnt, lk_e[c]);
            next_cycle();
        end

        // Forced release after MAX_LOCK locked cycles.
        do_reset();
        for (int c = 0; c < MAX_LOCK + 2; c++) begin
            drive((c == 0) ? 2'b10 : 2'b11, 2'b11, 2'b10, 10'd30, 10'd31, 32'hC0, 32'hC1);
            @(negedge clk);
            check($sformatf("force%0d gnt", c), req_gnt, (c <= MAX_LOCK) ? 2'b10 : 2'b01);
            next_cycle();
        end

        // Reset in the cycle after a locked read grant: response dropped, lock cleared.
        do_reset();
        drive(2'b01, 2'b00, 2'b01, 10'd5, 10'd0, 32'h0, 32'h0);
        @(negedge clk);
        check("rstmid_a gnt", req_gnt, 2'b01);
        rst_n = 1'b0;
        #1;
        check("rstmid_a gated gnt", req_gnt, 2'b00);
        check("rstmid_a gated mem_read", mem_read, 1'b0);
        next_cycle();
        check("rstmid_a rsp_valid", rsp_valid, 2'b00);
        next_cycle();
        rst_n = 1'b1;
        drive(2'b10, 2'b00, 2'b00, 10'd0, 10'd10, 32'h0, 32'h0);
        @(negedge clk);
        check("rstmid_a idle gnt", req_gnt, 2'b10);
        next_cycle();
        check("rstmid_a post rsp_valid", rsp_valid, 2'b10);
        check("rstmid_a post rsp_rdata", rsp_rdata, 32'h12345678);

        // Reset after a plain read grant: pointer returns to 0.
        drive(2'b01, 2'b00, 2'b00, 10'd5, 10'd0, 32'h0, 32'h0);
        @(negedge clk);
        check("rstmid_b gnt", req_gnt, 2'b01);
        rst_n = 1'b0;
        next_cycle();
        check("rstmid_b rsp_valid", rsp_valid, 2'b00);
        next_cycle();
        rst_n = 1'b1;
        drive(2'b11, 2'b00, 2'b00, 10'd5, 10'd10, 32'h0, 32'h0);
        @(negedge clk);
        check("rstmid_b ptr gnt", req_gnt, 2'b01);
        next_cycle();
        drive(2'b00, 2'b00, 2'b00, 10'd0, 10'd0, 32'h0, 32'h0);
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
